// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD accumulator slice.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADD_ONES = 2'd1,
    ADD_TENS = 2'd2,
    FINISH   = 2'd3
  } state_t;

  localparam logic [4:0] BCD_MAX = 5'd9;
  localparam logic [4:0] BCD_ADJ = 5'd6;

  // One-digit BCD add; returns {carry, digit}. A raw sum above 9 is
  // corrected by +6 so the low nibble wraps back into 0..9.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (s > BCD_MAX) begin
      s = s + BCD_ADJ;
      bcd_digit_add = {1'b1, s[3:0]};
    end else begin
      bcd_digit_add = {1'b0, s[3:0]};
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: two-flop synchronizer, stable-level debounce,
// and a one-cycle pulse on each debounced press (1 -> 0).
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          db_level;
  logic [CW-1:0] cnt;
  logic [1:0]    flush;
  logic          armed;

  // Presses are only armed once a released level has come through the
  // flushed synchronizer, so a key held down across reset exit is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      db_level <= 1'b1;
      cnt      <= '0;
      flush    <= '0;
      armed    <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      flush <= {flush[0], 1'b1};
      if (flush[1] && sync2) begin
        armed <= 1'b1;
      end
      press <= 1'b0;
      if (sync2 != db_level) begin
        if (cnt == CNT_LAST) begin
          db_level <= sync2;
          cnt      <= '0;
          press    <= armed & ~sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/bcd_accumulator.sv
// Two-digit BCD accumulator driven by a debounced pushbutton.
module bcd_accumulator
  import bcd_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic [8:0] SW,
  output logic [3:0] ONES,
  output logic [3:0] TENS,
  output logic       OVF,
  output logic       ERR,
  output logic       BUSY,
  output logic       DONE
);

  state_t     state, state_n;
  logic [3:0] operand, operand_n;
  logic       carry, carry_n;
  logic [3:0] ones_n, tens_n;
  logic       ovf_n, err_n;
  logic [4:0] sum;
  logic       press;
  logic       unused_sw;

  assign unused_sw = ^SW[7:4];

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key (
    .clk   (CLOCK_50),
    .rst_n (KEY0),
    .key_in(KEY1),
    .press (press)
  );

  // Next-state and datapath updates; everything holds unless the state acts on it.
  always_comb begin
    state_n   = state;
    operand_n = operand;
    carry_n   = carry;
    ones_n    = ONES;
    tens_n    = TENS;
    ovf_n     = OVF;
    err_n     = ERR;
    sum       = '0;
    case (state)
      IDLE: begin
        if (SW[8]) begin
          ones_n = '0;
          tens_n = '0;
          ovf_n  = 1'b0;
          err_n  = 1'b0;
        end else if (press) begin
          if ({1'b0, SW[3:0]} > BCD_MAX) begin
            err_n = 1'b1;
          end else begin
            operand_n = SW[3:0];
            state_n   = ADD_ONES;
          end
        end
      end
      ADD_ONES: begin
        sum     = bcd_digit_add(ONES, operand, 1'b0);
        ones_n  = sum[3:0];
        carry_n = sum[4];
        state_n = ADD_TENS;
      end
      ADD_TENS: begin
        sum    = bcd_digit_add(TENS, 4'd0, carry);
        tens_n = sum[3:0];
        if (sum[4]) begin
          ovf_n = 1'b1;
        end
        state_n = FINISH;
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; BUSY/DONE are registered from the next state
  // so they line up with the state they describe.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state   <= IDLE;
      operand <= '0;
      carry   <= 1'b0;
      ONES    <= '0;
      TENS    <= '0;
      OVF     <= 1'b0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_n;
      operand <= operand_n;
      carry   <= carry_n;
      ONES    <= ones_n;
      TENS    <= tens_n;
      OVF     <= ovf_n;
      ERR     <= err_n;
      BUSY    <= (state_n != IDLE);
      DONE    <= (state_n == FINISH);
    end
  end

endmodule

// File: tb/tb_bcd_accumulator.sv
// Directed bench for bcd_accumulator with a short debounce window.
module tb_bcd_accumulator;

  logic       clk = 1'b0;
  logic       key0, key1;
  logic [8:0] sw;
  logic [3:0] ONES, TENS;
  logic       OVF, ERR, BUSY, DONE;

  always #5 clk = ~clk;

  bcd_accumulator #(.DEB_CYCLES(4)) dut (
    .CLOCK_50(clk),
    .KEY0    (key0),
    .KEY1    (key1),
    .SW      (sw),
    .ONES    (ONES),
    .TENS    (TENS),
    .OVF     (OVF),
    .ERR     (ERR),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int bcd_bad  = 0;

  // Event counters sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (DONE === 1'b1) done_cnt <= done_cnt + 1;
    if (BUSY === 1'b1) busy_cnt <= busy_cnt + 1;
    if (ONES > 4'd9 || TENS > 4'd9) bcd_bad <= bcd_bad + 1;
  end

  typedef struct {
    bit         clr;
    logic [3:0] d;
    logic [3:0] tens;
    logic [3:0] ones;
    bit         ovf;
    bit         err;
    int         ndone;
  } vec_t;

  vec_t vt[6];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    sw   = {5'b0, d};
    key1 = 1'b0;
    step(hold);
    key1 = 1'b1;
    step(12);
  endtask

  task automatic clear_acc();
    sw[8] = 1'b1;
    step(1);
    sw[8] = 1'b0;
    step(2);
  endtask

  task automatic check_acc(input string nm, input logic [3:0] t, input logic [3:0] o,
                           input bit ov, input bit er);
    check({nm, "_tens"}, TENS, t);
    check({nm, "_ones"}, ONES, o);
    check({nm, "_ovf"}, OVF, ov);
    check({nm, "_err"}, ERR, er);
  endtask

  int d0, b0, k, bk;

  initial begin
    key0 = 1'b0;
    key1 = 1'b1;
    sw   = '0;
    step(3);
    check_acc("reset", 4'd0, 4'd0, 1'b0, 1'b0);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    key0 = 1'b1;
    step(5);

    // clr, digit, expected tens, ones, ovf, err, DONE pulses
    vt[0] = '{1'b0, 4'd7,  4'd0, 4'd7, 1'b0, 1'b0, 1};
    vt[1] = '{1'b0, 4'd5,  4'd1, 4'd2, 1'b0, 1'b0, 1};
    vt[2] = '{1'b0, 4'd9,  4'd2, 4'd1, 1'b0, 1'b0, 1};
    vt[3] = '{1'b0, 4'hC,  4'd2, 4'd1, 1'b0, 1'b1, 0};
    vt[4] = '{1'b0, 4'd0,  4'd2, 4'd1, 1'b0, 1'b1, 1};
    vt[5] = '{1'b1, 4'd0,  4'd0, 4'd0, 1'b0, 1'b0, 0};

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      b0 = busy_cnt;
      if (vt[i].clr) clear_acc();
      else press(vt[i].d, 10);
      check_acc($sformatf("vec%0d", i), vt[i].tens, vt[i].ones, vt[i].ovf, vt[i].err);
      check($sformatf("vec%0d_done", i), done_cnt - d0, vt[i].ndone);
      check($sformatf("vec%0d_busy", i), busy_cnt - b0, 3 * vt[i].ndone);
    end

    // Latency, operand isolation and SW[8] ignored while busy.
    sw   = 9'd3;
    key1 = 1'b0;
    k    = 0;
    bk   = -1;
    while (DONE !== 1'b1 && k < 30) begin
      step(1);
      k++;
      if (BUSY === 1'b1 && bk < 0) begin
        bk = k;
        sw = 9'h109;
      end else begin
        sw[8] = 1'b0;
      end
    end
    check("press_to_done", (k >= 9 && k <= 10), 1);
    check("busy_to_done", k - bk, 2);
    check("done_ones", ONES, 3);
    key1 = 1'b1;
    step(12);
    check_acc("inflight", 4'd0, 4'd3, 1'b0, 1'b0);

    // Preload 95, then wrap past 99.
    clear_acc();
    for (int i = 0; i < 10; i++) press(4'd9, 10);
    press(4'd5, 10);
    check_acc("pre95", 4'd9, 4'd5, 1'b0, 1'b0);
    d0 = done_cnt;
    press(4'd8, 10);
    check_acc("wrap", 4'd0, 4'd3, 1'b1, 1'b0);
    check("wrap_done", done_cnt - d0, 1);
    press(4'd7, 10);
    check_acc("ovf_sticky", 4'd1, 4'd0, 1'b1, 1'b0);
    clear_acc();
    check_acc("clear", 4'd0, 4'd0, 1'b0, 1'b0);

    // Glitch and bounce, then a clean hold: exactly one addition.
    d0 = done_cnt;
    sw = 9'd4;
    key1 = 1'b0; step(3);
    key1 = 1'b1; step(3);
    for (int i = 0; i < 5; i++) begin
      key1 = 1'b0; step(2);
      key1 = 1'b1; step(1);
    end
    step(6);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_ones", ONES, 0);
    key1 = 1'b0; step(10);
    key1 = 1'b1; step(12);
    check("bounce_done", done_cnt - d0, 1);
    check("bounce_ones", ONES, 4);

    // A long hold is still a single press.
    d0 = done_cnt;
    press(4'd1, 40);
    check("hold_done", done_cnt - d0, 1);
    check("hold_ones", ONES, 5);

    // Reset during ADD_TENS, key held through reset exit.
    sw   = 9'd2;
    key1 = 1'b0;
    k    = 0;
    while (BUSY !== 1'b1 && k < 30) begin
      step(1);
      k++;
    end
    check("busy_seen", BUSY, 1);
    step(1);
    key0 = 1'b0;
    d0   = done_cnt;
    step(1);
    check_acc("midrst", 4'd0, 4'd0, 1'b0, 1'b0);
    check("midrst_busy", BUSY, 0);
    check("midrst_done", DONE, 0);
    step(1);
    key0 = 1'b1;
    b0   = busy_cnt;
    step(20);
    key1 = 1'b1;
    step(12);
    check("rstexit_done", done_cnt - d0, 0);
    check("rstexit_busy", busy_cnt - b0, 0);
    check("rstexit_ones", ONES, 0);
    d0 = done_cnt;
    press(4'd6, 10);
    check("after_rst_done", done_cnt - d0, 1);
    check("after_rst_ones", ONES, 6);

    check("bcd_valid", bcd_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_accumulator.md
BCD_ACCUMULATOR -- requirements
Module: bcd_accumulator

Interface
REQ-001 Parameter DEB_CYCLES, default 500000: consecutive stable clock cycles a key level must hold before it is accepted (10 ms at 50 MHz).
REQ-002 CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-003 KEY0  input  1  reset; synchronous, active-low.
REQ-004 KEY1  input  1  add pushbutton, active-low, asynchronous to CLOCK_50, bouncing.
REQ-005 SW  input  9  SW[3:0] operand digit; SW[8] clear request (level, active-high); SW[7:4] unused.
REQ-006 ONES  output  4  accumulator units digit, BCD, drives a downstream seven-segment decoder.
REQ-007 TENS  output  4  accumulator tens digit, BCD.
REQ-008 OVF  output  1  sticky: an addition wrapped past 99.
REQ-009 ERR  output  1  sticky: a press occurred with SW[3:0] > 9.
REQ-010 BUSY  output  1  high while an addition is in progress.
REQ-011 DONE  output  1  one-cycle pulse when an addition completes.

Function
REQ-012 KEY1 SHALL pass through a two-flop synchronizer before any other use.
REQ-013 The debounced key level SHALL change only after the synchronized level has differed from it for DEB_CYCLES consecutive cycles; any reversion restarts the count from zero.
REQ-014 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; release generates no event.
REQ-015 FSM states: IDLE, ADD_ONES, ADD_TENS, FINISH; BUSY = 1 in ADD_ONES, ADD_TENS and FINISH.
REQ-016 IDLE, SW[8] = 1: ONES, TENS, OVF and ERR cleared next cycle; any press in the same cycle is discarded; state stays IDLE.
REQ-017 IDLE, press, SW[3:0] > 9: ERR set; accumulator unchanged; state stays IDLE.
REQ-018 IDLE, press, SW[3:0] <= 9: digit latched into an operand register; next state ADD_ONES.
REQ-019 ADD_ONES: s = ONES + operand (5-bit); if s > 9 then ONES = (s + 6)[3:0] and carry = 1, else ONES = s and carry = 0; next state ADD_TENS.
REQ-020 ADD_TENS: t = TENS + carry; if t > 9 then TENS = 0 and OVF set, else TENS = t; next state FINISH.
REQ-021 FINISH: DONE = 1 for exactly this cycle; next state IDLE.
REQ-022 Latency: DONE asserts 3 cycles after the cycle in which the press pulse is sampled in IDLE; the new value is visible on ONES/TENS in the FINISH cycle.
REQ-023 Press events and SW[8] SHALL be ignored in every state other than IDLE; SW[3:0] changes after latching SHALL NOT affect the addition in flight.
REQ-024 ONES and TENS SHALL always hold valid BCD (0..9); wrap 99 + 1 -> 00 with OVF = 1.
REQ-025 OVF and ERR remain set until reset or a clear (REQ-016).
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 KEY0 = 0 at a rising edge: state IDLE; ONES = TENS = 0; OVF = ERR = BUSY = DONE = 0; operand and carry = 0.
REQ-028 Reset SHALL preset the synchronizer flops and debounced level to 1 (released) and clear the debounce counter, so no press is generated on reset exit.
REQ-029 Reset mid-addition SHALL abandon the operation without a DONE pulse.

Structure
REQ-030 Shared package bcd_pkg holds the FSM state enumeration and the constants BCD_MAX = 9 and BCD_ADJ = 6.
REQ-031 Synchronizer, debounce and edge detection SHALL live in one sub-module, key_debounce (parameter DEB_CYCLES; ports: clock, reset, raw key in, press pulse out).

Verification (DEB_CYCLES = 4)
REQ-032 Reset, then SW = 7, clean press -> DONE after 3 cycles; TENS = 0, ONES = 7; OVF = ERR = 0.
REQ-033 From 07, SW = 5, press -> ONES = 2, TENS = 1 (12); a second SW = 9 press -> 21.
REQ-034 Preload 95, SW = 8, press -> 03 with OVF = 1; then SW[8] = 1 in IDLE -> 00, OVF = 0.
REQ-035 SW = 12 (4'hC), press -> ERR = 1, no BUSY, accumulator unchanged.
REQ-036 KEY1 glitches low for 3 cycles, then bounces 5 times before holding low for 10 cycles -> exactly one DONE; a press while BUSY produces no second addition.
REQ-037 KEY0 low during ADD_TENS -> next cycle all outputs 0, no DONE; a held KEY1 during reset exit generates no press.
